pc_fetch_unit: RTL

- Instruction-fetch front end of the pipelined CPU: owns the program counter, presents it to instruction memory, and drives the PC+4 Adder (pc_o -> Adder src1_i, constant 4 -> src2_i).
- Selects next PC from the Adder result or a branch/jump redirect, honours hazard-unit stalls and imem wait states.
- Loads the IF/ID pipeline register consumed by the decode stage.

---
 rtl/pc_fetch_unit_pkg.sv | 13 +
 rtl/pc_fetch_unit_ifid_reg.sv | 60 ++++++
 rtl/pc_fetch_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared constants and FSM encoding for the fetch front end
// Purpose: default reset PC, bubble instruction word and FETCH/DRAIN state encoding.
package pc_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_ifid_reg.sv
// rtl/pc_fetch_unit_ifid_reg.sv - IF/ID pipeline register with load, bubble and hold
// Purpose: holds the fetched instruction handed to decode.
// Ports:
//   clk_i, rst_i              clock, async active-high reset
//   load_i                    capture instr_i / pc_plus4_i, mark valid
//   bubble_i                  insert NOP_INSTR, mark invalid (pc_plus4 kept)
//   instr_i, pc_plus4_i       data to capture on load
//   valid_o, instr_o, pc_plus4_o  register contents
// Neither load nor bubble: all fields hold.
module pc_fetch_unit_ifid_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        bubble_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o
);

  logic        valid_q,    valid_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_plus4_d = pc_plus4_i;
    end else if (bubble_i) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_plus4_q <= 32'h0000_0000;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - instruction fetch front end: PC, imem request, IF/ID load
// Purpose: owns the PC, selects next PC from the external PC+4 adder or a
// redirect, honours stalls and imem wait states, and fills IF/ID.
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   pc_o, pc_plus4_i                 PC to imem/adder, adder result back
//   imem_req_o, imem_ready_i, instr_i  imem handshake and data
//   stall_i                          hazard-unit hold
//   redirect_i, redirect_pc_i        taken branch/jump and its target
//   ifid_valid_o, ifid_instr_o, ifid_pc_plus4_o  IF/ID contents
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  output logic        imem_req_o,
  input  logic        imem_ready_i,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_pc_plus4_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         ifid_load, ifid_bubble;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        if (redirect_i) begin
          ifid_bubble = 1'b1;
          if (imem_ready_i) begin
            pc_d = redirect_pc_i;
          end else begin
            // A fetch for the old PC is still outstanding; park the target
            // until imem answers so the stale word can be thrown away.
            pend_pc_d    = redirect_pc_i;
            pend_valid_d = 1'b1;
            state_d      = ST_DRAIN;
          end
        end else if (stall_i) begin
          // Hold everything, including while imem is still waiting.
        end else if (!imem_ready_i) begin
          ifid_bubble = 1'b1;
        end else begin
          pc_d      = pc_plus4_i;
          ifid_load = 1'b1;
        end
      end

      ST_DRAIN: begin
        ifid_bubble = 1'b1;
        if (redirect_i) begin
          pend_pc_d = redirect_pc_i;
        end
        if (imem_ready_i) begin
          // The returned word belongs to the abandoned path and is dropped.
          // A redirect arriving on the same edge is the newest target.
          if (redirect_i) begin
            pc_d = redirect_pc_i;
          end else if (pend_valid_q) begin
            pc_d = pend_pc_q;
          end
          pend_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  pc_fetch_unit_ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ifid_load),
    .bubble_i   (ifid_bubble),
    .instr_i    (instr_i),
    .pc_plus4_i (pc_plus4_i),
    .valid_o    (ifid_valid_o),
    .instr_o    (ifid_instr_o),
    .pc_plus4_o (ifid_pc_plus4_o)
  );

  assign pc_o       = pc_q;
  // Request is gated by reset directly so it drops the moment reset rises.
  assign imem_req_o = (state_q == ST_FETCH) && !rst_i;

endmodule
